// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the fetch PC, issues imem reads and queues {instr, pc} for decode.
// Optional perf counters (fetch/stall/flush) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_queue_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
    input  logic                       CLK,
    input  logic                       nRST,
    output logic                       imemREN,
    output logic [ADDR_W-1:0]          imemaddr,
    input  logic                       ihit,
    input  logic [DATA_W-1:0]          imemload,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [DATA_W-1:0]          deq_instr,
    output logic [ADDR_W-1:0]          deq_pc,
    output logic [ADDR_W-1:0]          deq_pc4,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       halt_req,
    output logic                       halt,
    output logic [$clog2(DEPTH):0]     occupancy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                fetch_cnt,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                flush_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] FULL_C = OW'(DEPTH);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        FULL   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic              run_q;

    logic [DATA_W-1:0] mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_pc    [DEPTH];

    logic push, pop, we, live;

    assign live      = (state_q != HALTED);
    assign imemREN   = run_q && (state_q == FETCH) && (occ_q != FULL_C);
    assign imemaddr  = pc_q;
    assign deq_valid = live && (occ_q != '0);
    assign deq_instr = mem_instr[rd_q];
    assign deq_pc    = mem_pc[rd_q];
    assign deq_pc4   = mem_pc[rd_q] + ADDR_W'(4);
    assign halt      = (state_q == HALTED);
    assign occupancy = occ_q;

    assign push = ihit && imemREN;
    assign pop  = deq_valid && deq_ready;
    // halt_req and redirect both discard the queue update of their cycle
    assign we   = push && !redirect && !halt_req;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        occ_d   = occ_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        unique case (state_q)
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                if (halt_req) begin
                    state_d = HALTED;
                end else if (redirect) begin
                    occ_d   = '0;
                    wr_d    = '0;
                    rd_d    = '0;
                    pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
                    state_d = FETCH;
                end else begin
                    if (push) begin
                        wr_d = wr_q + PW'(1);
                        pc_d = pc_q + ADDR_W'(4);
                    end
                    if (pop) begin
                        rd_d = rd_q + PW'(1);
                    end
                    unique case ({push, pop})
                        2'b10:   occ_d = occ_q + OW'(1);
                        2'b01:   occ_d = occ_q - OW'(1);
                        default: occ_d = occ_q;
                    endcase
                    state_d = (occ_d == FULL_C) ? FULL : FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            occ_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            occ_q   <= occ_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            run_q   <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_instr[wr_q] <= imemload;
            mem_pc[wr_q]    <= pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_q, stall_q, flush_q;

    assign fetch_cnt = fetch_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else if (live) begin
            if (we && fetch_q != '1) begin
                fetch_q <= fetch_q + 32'd1;
            end
            if (imemREN && !ihit && stall_q != '1) begin
                stall_q <= stall_q + 32'd1;
            end
            if (redirect && !halt_req && flush_q != '1) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end
`endif

endmodule
